// File: rtl/branch_pkg.sv
// Shared types and default sizing for the branch resolver.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2,
    RES  = 2'd3
  } resolver_state_t;

  localparam int BR_DEPTH = 4;
  localparam int BR_CNT_W = 16;

endpackage

// File: rtl/branch_resolver_if.sv
// Pipeline and predictor handshake bundle for the branch resolver.
interface branch_resolver_if;

  logic fetch_valid;
  logic fetch_ready;
  logic pred_out_valid;
  logic pred_out;
  logic resolve_valid;
  logic resolve_taken;
  logic resolve_ready;
  logic mispredict_valid;
  logic mispredict;
  logic request;
  logic result;
  logic taken;
  logic prediction;

  // slave is the resolver itself; master is the pipeline/predictor side
  modport slave (
    input  fetch_valid, resolve_valid, resolve_taken, prediction,
    output fetch_ready, pred_out_valid, pred_out, resolve_ready,
           mispredict_valid, mispredict, request, result, taken
  );

  modport master (
    output fetch_valid, resolve_valid, resolve_taken, prediction,
    input  fetch_ready, pred_out_valid, pred_out, resolve_ready,
           mispredict_valid, mispredict, request, result, taken
  );

endinterface

// File: rtl/pred_fifo.sv
// In-order queue of 1-bit predictions for in-flight branches.
module pred_fifo #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          head,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Issues predictor requests for fetched branches, queues the predictions and
// reports mispredicts as branches resolve in order.
module branch_resolver
  import branch_pkg::*;
#(
  parameter  int DEPTH = BR_DEPTH,
  parameter  int CNT_W = BR_CNT_W,
  localparam int IW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolver_if.slave  bus,
  output logic [IW-1:0]     inflight,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  resolver_state_t state;
  resolver_state_t state_nxt;
  logic            not_empty;
  logic            fetch_go;
  logic            resolve_go;
  logic            head;

  assign not_empty  = (inflight != '0);
  // resolve wins a tie: it is older and frees a slot
  assign bus.resolve_ready = (state == IDLE) && not_empty;
  assign bus.fetch_ready   = (state == IDLE) && (inflight < IW'(DEPTH)) &&
                             !(bus.resolve_valid && not_empty);
  assign resolve_go = bus.resolve_valid && bus.resolve_ready;
  assign fetch_go   = bus.fetch_valid && bus.fetch_ready;

  assign bus.pred_out_valid   = (state == CAPT);
  assign bus.pred_out         = bus.prediction;
  assign bus.mispredict_valid = (state == RES);
  assign bus.mispredict       = head ^ bus.taken;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (resolve_go) state_nxt = RES;
               else if (fetch_go) state_nxt = REQ;
      REQ:     state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      RES:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // request/result decode the next state, so they are registered and exclusive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bus.request      <= 1'b0;
      bus.result       <= 1'b0;
      bus.taken        <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      state       <= state_nxt;
      bus.request <= (state_nxt == REQ);
      bus.result  <= (state_nxt == RES);
      if (resolve_go)
        bus.taken <= bus.resolve_taken;
      if (state == RES) begin
        branch_count <= sat_inc(branch_count);
        if (bus.mispredict)
          mispredict_count <= sat_inc(mispredict_count);
      end
    end
  end

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (state == CAPT),
    .din   (bus.prediction),
    .pop   (state == RES),
    .head  (head),
    .count (inflight)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a 2-bit saturating predictor model.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst2;
  logic [2:0]  inflight;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;
  logic [2:0]  inflight2;
  logic [3:0]  branch_count2;
  logic [3:0]  mispredict_count2;

  int passed = 0;
  int total  = 0;
  int mutex_err = 0;

  logic [1:0] ctr = 2'b11;

  branch_resolver_if bus ();
  branch_resolver_if bus2 ();

  branch_resolver #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .inflight(inflight), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  branch_resolver #(.DEPTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst2), .bus(bus2),
    .inflight(inflight2), .branch_count(branch_count2),
    .mispredict_count(mispredict_count2)
  );

  // second instance: always predicts taken, every branch resolves not-taken
  assign bus2.fetch_valid   = 1'b1;
  assign bus2.resolve_valid = 1'b1;
  assign bus2.resolve_taken = 1'b0;
  assign bus2.prediction    = 1'b1;

  always #5 clk = ~clk;

  // predictor model, independent of the resolver reset
  always @(posedge clk) begin
    if (bus.request) bus.prediction <= ctr[1];
    if (bus.result) begin
      if (bus.taken && ctr != 2'b11) ctr <= ctr + 2'b01;
      else if (!bus.taken && ctr != 2'b00) ctr <= ctr - 2'b01;
    end
  end

  always @(negedge clk) begin
    if (bus.request && bus.result) mutex_err++;
    if (bus2.request && bus2.result) mutex_err++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic do_fetch(input logic exp_pred, input logic [2:0] exp_infl);
    int n = 0;
    bus.fetch_valid = 1'b1;
    while (!bus.fetch_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("fetch_ready", bus.fetch_ready, 1);
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
    chk("request", bus.request, 1);
    @(posedge clk); #1;
    chk("pred_out_valid", bus.pred_out_valid, 1);
    chk("pred_out", bus.pred_out, exp_pred);
    chk("request_pulse", bus.request, 0);
    @(posedge clk); #1;
    chk("inflight_fetch", inflight, exp_infl);
  endtask

  task automatic do_resolve(input logic tkn, input logic exp_mis, input logic [2:0] exp_infl,
                            input logic [15:0] exp_bc, input logic [15:0] exp_mc);
    int n = 0;
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = tkn;
    while (!bus.resolve_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("resolve_ready", bus.resolve_ready, 1);
    @(posedge clk); #1;
    bus.resolve_valid = 1'b0;
    chk("result", bus.result, 1);
    chk("taken", bus.taken, tkn);
    chk("mispredict_valid", bus.mispredict_valid, 1);
    chk("mispredict", bus.mispredict, exp_mis);
    @(posedge clk); #1;
    chk("result_pulse", bus.result, 0);
    chk("inflight_res", inflight, exp_infl);
    chk("branch_count", branch_count, exp_bc);
    chk("mispredict_count", mispredict_count, exp_mc);
  endtask

  typedef struct {
    logic        is_fetch;
    logic        tkn;
    logic        exp_bit;
    logic [2:0]  exp_infl;
    logic [15:0] exp_bc;
    logic [15:0] exp_mc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int seen;
    vecs[0] = '{1'b1, 1'b0, 1'b1, 3'd1, 16'd0, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 3'd0, 16'd1, 16'd1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 3'd1, 16'd1, 16'd1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 3'd2, 16'd1, 16'd1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd1, 16'd2, 16'd2};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 3'd0, 16'd3, 16'd3};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 3'd1, 16'd3, 16'd3};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 3'd0, 16'd4, 16'd3};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 3'd1, 16'd4, 16'd3};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 3'd0, 16'd5, 16'd4};

    rst = 1'b1; rst2 = 1'b1;
    bus.fetch_valid = 1'b0; bus.resolve_valid = 1'b0; bus.resolve_taken = 1'b0;
    bus.prediction = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_request", bus.request, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_taken", bus.taken, 0);
    chk("rst_pred_out_valid", bus.pred_out_valid, 0);
    chk("rst_mispredict_valid", bus.mispredict_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_branch_count", branch_count, 0);
    chk("rst_mispredict_count", mispredict_count, 0);
    chk("rst_resolve_ready", bus.resolve_ready, 0);
    @(negedge clk); rst = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_fetch) do_fetch(vecs[i].exp_bit, vecs[i].exp_infl);
      else do_resolve(vecs[i].tkn, vecs[i].exp_bit, vecs[i].exp_infl,
                      vecs[i].exp_bc, vecs[i].exp_mc);
    end

    // fill the queue, then a fifth fetch waits for a resolve
    do_fetch(1'b0, 3'd1);
    do_fetch(1'b0, 3'd2);
    do_fetch(1'b0, 3'd3);
    do_fetch(1'b0, 3'd4);
    chk("full_fetch_ready", bus.fetch_ready, 0);
    bus.fetch_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("full_stall_request", bus.request, 0);
    chk("full_stall_ready", bus.fetch_ready, 0);
    bus.resolve_valid = 1'b1; bus.resolve_taken = 1'b0;
    @(posedge clk); #1;
    bus.resolve_valid = 1'b0;
    chk("full_result", bus.result, 1);
    chk("full_no_request", bus.request, 0);
    chk("full_mispredict", bus.mispredict, 0);
    @(posedge clk); #1;
    chk("full_inflight", inflight, 3);
    chk("full_branch_count", branch_count, 6);
    chk("full_ready_again", bus.fetch_ready, 1);
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
    chk("full_late_request", bus.request, 1);
    @(posedge clk); #1;
    chk("full_pred_out", bus.pred_out, 0);
    @(posedge clk); #1;
    chk("full_refill", inflight, 4);

    // simultaneous fetch and resolve at inflight 2
    do_resolve(1'b0, 1'b0, 3'd3, 16'd7, 16'd4);
    do_resolve(1'b0, 1'b0, 3'd2, 16'd8, 16'd4);
    bus.fetch_valid = 1'b1; bus.resolve_valid = 1'b1; bus.resolve_taken = 1'b1;
    @(posedge clk); #1;
    bus.resolve_valid = 1'b0;
    chk("both_result_first", bus.result, 1);
    chk("both_no_request", bus.request, 0);
    chk("both_mispredict", bus.mispredict, 1);
    @(posedge clk); #1;
    chk("both_idle_request", bus.request, 0);
    chk("both_inflight", inflight, 1);
    chk("both_mispredict_count", mispredict_count, 5);
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
    chk("both_fetch_2_later", bus.request, 1);
    @(posedge clk); #1;
    chk("both_pred_out", bus.pred_out, 0);
    @(posedge clk); #1;
    chk("both_inflight_end", inflight, 2);

    do_resolve(1'b0, 1'b0, 3'd1, 16'd10, 16'd5);
    do_resolve(1'b0, 1'b0, 3'd0, 16'd11, 16'd5);

    // resolve on empty queue stalls
    bus.resolve_valid = 1'b1; bus.resolve_taken = 1'b1;
    seen = 0;
    #1;
    chk("empty_resolve_ready", bus.resolve_ready, 0);
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.result || bus.mispredict_valid) seen++;
    end
    bus.resolve_valid = 1'b0;
    chk("empty_no_result", seen, 0);
    chk("empty_branch_count", branch_count, 11);
    chk("empty_mispredict_count", mispredict_count, 5);

    // reset during CAPT discards the pending push
    bus.fetch_valid = 1'b1;
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
    @(posedge clk); #1;
    chk("capt_pred_out_valid", bus.pred_out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_capt_pred_out_valid", bus.pred_out_valid, 0);
    chk("rst_capt_request", bus.request, 0);
    chk("rst_capt_result", bus.result, 0);
    chk("rst_capt_mispredict_valid", bus.mispredict_valid, 0);
    chk("rst_capt_inflight", inflight, 0);
    chk("rst_capt_branch_count", branch_count, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_capt_no_push", inflight, 0);

    repeat (120) @(posedge clk);
    #1;
    chk("sat_mispredict_count", mispredict_count2, 15);
    chk("sat_branch_count", branch_count2, 15);
    chk("req_res_mutex", mutex_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
